// File: rtl/udp_line_scheduler.sv
// Multi-camera line scheduler: picks one ready camera line, triggers a UDP packet for it,
// counts the packet engine's byte reads, releases the buffer and holds an inter-packet gap.
// Optional statistics counters are built when LINE_SCHED_STATS_EN is defined.
module udp_line_scheduler #(
    parameter int N_CAM       = 2,
    parameter int ROW_W       = 11,
    parameter int ID_W        = 5,
    parameter int LINE_BYTES  = 1280,
    parameter int ARB_MODE    = 0,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535,
    localparam int SEL_W      = (N_CAM > 1) ? $clog2(N_CAM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_CAM-1:0]         line_ready,
    input  logic [N_CAM*ROW_W-1:0]   line_row,
    input  logic                     tx_read_en,
    output logic                     tx_trig,
    output logic [SEL_W-1:0]         tx_sel,
    output logic [ID_W+ROW_W-1:0]    tx_index,
    output logic [N_CAM-1:0]         line_release,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [N_CAM*16-1:0]      sent_count,
    output logic [15:0]              drop_count,
    output logic [2:0]               state_dbg
);
    localparam int BYTE_W = $clog2(LINE_BYTES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARB  = 3'd1;
    localparam logic [2:0] TRIG = 3'd2;
    localparam logic [2:0] XFER = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;

    logic [2:0]        state, state_d;
    logic [BYTE_W-1:0] byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [SEL_W-1:0]  rr_ptr, win, rr_idx;
    logic [ROW_W-1:0]  rows [N_CAM];
    logic [N_CAM-1:0]  rel_mask;
    logic              in_line, done, abort, arb_go;
    int                rr_sum;

    assign state_dbg = state;

    always_comb begin
        for (int i = 0; i < N_CAM; i++) rows[i] = line_row[i*ROW_W +: ROW_W];
    end

    // Winner search: the loops run from the far end so the last hit is the preferred one.
    always_comb begin
        win    = '0;
        rr_idx = '0;
        rr_sum = 0;
        if (ARB_MODE == 1) begin
            for (int i = N_CAM - 1; i >= 0; i--)
                if (line_ready[i]) win = SEL_W'(i);
        end else begin
            for (int off = N_CAM; off >= 1; off--) begin
                rr_sum = int'(rr_ptr) + off;
                if (rr_sum >= N_CAM) rr_sum = rr_sum - N_CAM;
                rr_idx = SEL_W'(rr_sum);
                if (line_ready[rr_idx]) win = rr_idx;
            end
        end
    end

    always_comb begin
        rel_mask         = '0;
        rel_mask[tx_sel] = 1'b1;
    end

    // tx_read_en is a bare strobe from the packet engine: each high cycle in TRIG/XFER
    // consumes exactly one byte; there is no back-pressure path towards udp_packet.
    assign in_line = (state == TRIG) || (state == XFER);
    assign done    = in_line && tx_read_en && (byte_cnt == BYTE_W'(LINE_BYTES - 1));
    assign abort   = in_line && !tx_read_en && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign arb_go  = (state == ARB) && (|line_ready);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (enable && (|line_ready)) state_d = ARB;
            ARB:        state_d = arb_go ? TRIG : IDLE;
            TRIG, XFER: state_d = (done || abort) ? GAP : XFER;
            GAP:        if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            tx_trig      <= 1'b0;
            tx_sel       <= '0;
            tx_index     <= '0;
            line_release <= '0;
            err_timeout  <= 1'b0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            rr_ptr       <= SEL_W'(N_CAM - 1);
        end else begin
            state        <= state_d;
            busy         <= (state_d != IDLE);
            tx_trig      <= arb_go;
            line_release <= '0;
            if (state == ARB) begin
                byte_cnt <= '0;
                tmo_cnt  <= '0;
            end
            if (arb_go) begin
                tx_sel   <= win;
                tx_index <= {ID_W'(win), rows[win]};
            end
            if (in_line) begin
                if (tx_read_en) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt  <= tmo_cnt + 1'b1;
                end
            end
            if (done || abort) begin
                line_release <= rel_mask;
                gap_cnt      <= '0;
            end else if (state == GAP) begin
                gap_cnt      <= gap_cnt + 1'b1;
            end
            if (done) rr_ptr <= tx_sel;
            if (abort) err_timeout <= 1'b1;
        end
    end

`ifdef LINE_SCHED_STATS_EN
    logic [15:0] sent_q [N_CAM];
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CAM; i++) sent_q[i] <= '0;
            drop_q <= '0;
        end else begin
            if (done && (sent_q[tx_sel] != 16'hFFFF)) sent_q[tx_sel] <= sent_q[tx_sel] + 16'd1;
            if (abort && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CAM; i++) sent_count[i*16 +: 16] = sent_q[i];
    end
    assign drop_count = drop_q;
`else
    assign sent_count = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_udp_line_scheduler.sv
// Bench for udp_line_scheduler: a round-robin and a fixed-priority instance share all inputs
// and are checked against a transaction-level model of arbitration, release and gap timing.
module tb_udp_line_scheduler;
    localparam int N     = 4;
    localparam int ROW_W = 11;
    localparam int ID_W  = 5;
    localparam int LB    = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst, enable, rd;
    logic [N-1:0]       rdy;
    logic [N*ROW_W-1:0] rows;

    logic               rr_trig, fp_trig, rr_busy, fp_busy, rr_err, fp_err;
    logic [1:0]         rr_sel, fp_sel;
    logic [15:0]        rr_idx, fp_idx, rr_drop, fp_drop;
    logic [N-1:0]       rr_rel, fp_rel;
    logic [N*16-1:0]    rr_sent, fp_sent;
    logic [2:0]         rr_state, fp_state;

    int tests = 0;
    int fails = 0;
    int rr_last;
    int sent_rr [N];
    int sent_fp [N];
    int drops;
    logic exp_err;

    always #5 clk = ~clk;

    udp_line_scheduler #(.N_CAM(N), .ROW_W(ROW_W), .ID_W(ID_W), .LINE_BYTES(LB), .ARB_MODE(0),
                         .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) u_rr (
        .clk(clk), .rst(rst), .enable(enable), .line_ready(rdy), .line_row(rows),
        .tx_read_en(rd), .tx_trig(rr_trig), .tx_sel(rr_sel), .tx_index(rr_idx),
        .line_release(rr_rel), .busy(rr_busy), .err_timeout(rr_err),
        .sent_count(rr_sent), .drop_count(rr_drop), .state_dbg(rr_state));

    udp_line_scheduler #(.N_CAM(N), .ROW_W(ROW_W), .ID_W(ID_W), .LINE_BYTES(LB), .ARB_MODE(1),
                         .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) u_fp (
        .clk(clk), .rst(rst), .enable(enable), .line_ready(rdy), .line_row(rows),
        .tx_read_en(rd), .tx_trig(fp_trig), .tx_sel(fp_sel), .tx_index(fp_idx),
        .line_release(fp_rel), .busy(fp_busy), .err_timeout(fp_err),
        .sent_count(fp_sent), .drop_count(fp_drop), .state_dbg(fp_state));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r);
        int c;
        for (int off = 1; off <= N; off++) begin
            c = (rr_last + off) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic int fp_pick(input logic [N-1:0] r);
        for (int c = 0; c < N; c++) if (r[c]) return c;
        return 0;
    endfunction

    task automatic model_reset();
        rr_last = N - 1;
        drops   = 0;
        exp_err = 1'b0;
        for (int c = 0; c < N; c++) begin
            sent_rr[c] = 0;
            sent_fp[c] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trig"}, {rr_trig, fp_trig}, 2'b00);
        check({tag, "_sel"}, {rr_sel, fp_sel}, 4'h0);
        check({tag, "_idx"}, {rr_idx, fp_idx}, 32'h0);
        check({tag, "_rel"}, {rr_rel, fp_rel}, 8'h0);
        check({tag, "_busy"}, {rr_busy, fp_busy}, 2'b00);
        check({tag, "_err"}, {rr_err, fp_err}, 2'b00);
        check({tag, "_sent"}, rr_sent | fp_sent, 64'h0);
        check({tag, "_drop"}, {rr_drop, fp_drop}, 32'h0);
    endtask

    task automatic check_stats();
`ifdef LINE_SCHED_STATS_EN
        for (int c = 0; c < N; c++) begin
            check("sent_rr", rr_sent[c*16 +: 16], 64'(sent_rr[c]));
            check("sent_fp", fp_sent[c*16 +: 16], 64'(sent_fp[c]));
        end
        check("drop_rr", rr_drop, 64'(drops));
        check("drop_fp", fp_drop, 64'(drops));
`else
        check("sent_off", rr_sent | fp_sent, 64'h0);
        check("drop_off", {rr_drop, fp_drop}, 64'h0);
`endif
    endtask

    // Runs one line from an IDLE cycle whose ready/row inputs are already applied.
    // nreads < LB leaves the line to time out; en_off drops enable halfway through.
    task automatic do_line(input int nreads, input bit en_off);
        int wr, wf, g;
        bit complete;
        logic [15:0] ei_r, ei_f;
        logic [N-1:0] rdy_s;
        logic [N*ROW_W-1:0] rows_s;
        complete = (nreads == LB);
        wr   = rr_pick(rdy);
        wf   = fp_pick(rdy);
        ei_r = {5'(wr), rows[wr*ROW_W +: ROW_W]};
        ei_f = {5'(wf), rows[wf*ROW_W +: ROW_W]};
        tick();
        check("arb_busy", {rr_busy, fp_busy}, 2'b11);
        check("arb_trig", {rr_trig, fp_trig}, 2'b00);
        tick();
        check("trig", {rr_trig, fp_trig}, 2'b11);
        check("sel_rr", rr_sel, 64'(wr));
        check("sel_fp", fp_sel, 64'(wf));
        check("idx_rr", rr_idx, ei_r);
        check("idx_fp", fp_idx, ei_f);
        rdy_s = rdy;
        rows_s = rows;
        rdy  = 4'($urandom);
        rows = 44'({$urandom(), $urandom()});
        for (int k = 0; k < nreads; k++) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                tick();
                check("xfer_trig", {rr_trig, fp_trig}, 2'b00);
                check("xfer_rel", {rr_rel, fp_rel}, 8'h0);
            end
            if (en_off && k == nreads / 2) enable = 1'b0;
            rd = 1'b1;
            tick();
            rd = 1'b0;
            if (!(complete && k == nreads - 1)) begin
                check("read_rel", {rr_rel, fp_rel}, 8'h0);
                check("read_busy", {rr_busy, fp_busy}, 2'b11);
            end
        end
        if (!complete) begin
            repeat (TMO - 1) begin
                tick();
                check("tmo_wait_rel", {rr_rel, fp_rel}, 8'h0);
            end
            tick();
            drops++;
            exp_err = 1'b1;
        end else begin
            sent_rr[wr]++;
            sent_fp[wf]++;
            rr_last = wr;
        end
        check("rel_rr", rr_rel, 64'(1 << wr));
        check("rel_fp", fp_rel, 64'(1 << wf));
        check("stable_sel", {rr_sel, fp_sel}, {2'(wr), 2'(wf)});
        check("stable_idx", {rr_idx, fp_idx}, {ei_r, ei_f});
        rdy = rdy_s;
        rows = rows_s;
        repeat (GAP - 1) begin
            tick();
            check("gap_busy", {rr_busy, fp_busy}, 2'b11);
            check("gap_trig_rel", {rr_trig, fp_trig, rr_rel, fp_rel}, 10'h0);
        end
        tick();
        check("gap_end_idle", {rr_busy, fp_busy}, 2'b00);
        check("err", {rr_err, fp_err}, {exp_err, exp_err});
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; rd = 1'b0; rdy = '0; rows = '0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("post_reset_idle", {rr_busy, fp_busy, rr_trig, fp_trig}, 4'h0);
        enable = 1'b1;

        // All cameras ready: round-robin walks 0,1,2,3,0; fixed priority stays on 0.
        rdy = 4'b1111;
        for (int l = 0; l < 5; l++) begin
            rows = 44'({$urandom(), $urandom()});
            do_line(LB, 1'b0);
        end

        for (int l = 0; l < 6; l++) begin
            rdy  = 4'($urandom_range(1, 15));
            rows = 44'({$urandom(), $urandom()});
            do_line(LB, 1'b0);
        end

        rdy = 4'b1010;
        for (int l = 0; l < 3; l++) begin
            rows = 44'({$urandom(), $urandom()});
            do_line(LB, 1'b0);
        end

        // Ready withdrawn while arbitrating: no trigger, back to idle.
        rdy = 4'b0100;
        tick();
        check("drop_arb_busy", {rr_busy, fp_busy}, 2'b11);
        rdy = 4'b0000;
        tick();
        check("drop_arb_idle", {rr_busy, fp_busy, rr_trig, fp_trig}, 4'h0);
        tick();
        check("drop_arb_notrig", {rr_busy, fp_busy, rr_trig, fp_trig}, 4'h0);

        rdy  = 4'b1111;
        rows = 44'({$urandom(), $urandom()});
        do_line(5, 1'b0);
        check_stats();
        rows = 44'({$urandom(), $urandom()});
        do_line(LB, 1'b0);

        // Enable dropped mid-line: the line finishes and nothing new starts.
        rows = 44'({$urandom(), $urandom()});
        do_line(LB, 1'b1);
        repeat (8) begin
            tick();
            check("disabled_idle", {rr_busy, fp_busy, rr_trig, fp_trig}, 4'h0);
        end
        enable = 1'b1;
        rows = 44'({$urandom(), $urandom()});
        do_line(LB, 1'b0);
        check_stats();

        // Reset in the middle of a transfer.
        rdy = 4'b1111;
        tick();
        tick();
        check("pre_rst_trig", {rr_trig, fp_trig}, 2'b11);
        rd = 1'b1;
        repeat (3) tick();
        check("pre_rst_err", {rr_err, fp_err}, 2'b11);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        rd = 1'b0;
        model_reset();
        tick();
        check_reset_outputs("held_rst");
        rst = 1'b0;
        rows = 44'({$urandom(), $urandom()});
        do_line(LB, 1'b0);
        do_line(LB, 1'b0);
        check_stats();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
